// File: rtl/cprv_pkg.sv
// Shared types and constants for the cprv load/store unit.
// Holds the bus widths, funct3 size encodings, the LSU state enum and request-error decode.
package cprv_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // Undefined encoding, unsigned stores, or a natural-alignment violation.
  function automatic logic lsu_req_err(input logic is_load, input logic [2:0] funct3,
                                       input logic [2:0] offset);
    logic err;
    err = 1'b0;
    if (funct3 == 3'b111 || (!is_load && funct3[2])) begin
      err = 1'b1;
    end else begin
      case (funct3[1:0])
        2'b01:   err = offset[0];
        2'b10:   err = |offset[1:0];
        2'b11:   err = |offset;
        default: err = 1'b0;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/cprv_lsu_align.sv
// Byte-lane alignment for the LSU: store strobes and lane shift, load extraction and extension.
// Purely combinational; the caller decides when each result is meaningful.
module cprv_lsu_align #(
  parameter int DATA_WIDTH = cprv_pkg::DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [2:0]            offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [7:0]            wstrb,
  output logic [DATA_WIDTH-1:0] wdata_lane,
  output logic [DATA_WIDTH-1:0] rdata_ext
);
  import cprv_pkg::*;

  logic [7:0]            size_mask;
  logic [5:0]            bit_off;
  logic [DATA_WIDTH-1:0] rshift;

  always_comb begin
    bit_off = {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    wstrb      = size_mask << offset;
    wdata_lane = wdata << bit_off;

    rshift = rdata >> bit_off;
    case (funct3)
      F3_B:    rdata_ext = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_ext = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
      F3_W:    rdata_ext = {{(DATA_WIDTH-32){rshift[31]}}, rshift[31:0]};
      F3_D:    rdata_ext = rshift;
      F3_BU:   rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
      F3_HU:   rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
      F3_WU:   rdata_ext = {{(DATA_WIDTH-32){1'b0}}, rshift[31:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/cprv_lsu.sv
// Single-outstanding load/store unit: accepts one memory op from execute, issues one
// aligned doubleword bus request, and returns a one-cycle completion to writeback.
module cprv_lsu #(
  parameter int DATA_WIDTH = cprv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cprv_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_err
);
  import cprv_pkg::*;

  lsu_state_e            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] ldata_q, ldata_d;

  logic [7:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  in_req, in_resp, is_store;

  cprv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_ext)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so paths that do not assign it cannot infer a latch.
    state_d   = state_q;
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    ldata_d   = ldata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          is_load_d = req_is_load;
          funct3_d  = req_funct3;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rd_d      = req_rd;
          ldata_d   = '0;
          err_d     = lsu_req_err(req_is_load, req_funct3, req_addr[2:0]);
          state_d   = err_d ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          ldata_d = load_ext;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Held low for the first cycle after reset release, then tracks IDLE.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      ldata_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values independent of order.
      state_q   <= state_d;
      ready_q   <= ready_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      ldata_q   <= ldata_d;
    end
  end

  // Outputs decode only from flops, and are forced to zero outside the state that owns them.
  assign in_req   = (state_q == ST_REQ);
  assign in_resp  = (state_q == ST_RESP);
  assign is_store = in_req && !is_load_q;

  assign req_ready     = ready_q;
  assign mem_req_valid = in_req;
  assign mem_we        = is_store;
  assign mem_addr      = in_req ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign mem_wdata     = is_store ? lane_wdata : '0;
  assign mem_wstrb     = is_store ? lane_strb : 8'h00;

  assign wb_valid = in_resp;
  assign wb_rd    = in_resp ? rd_q : 5'd0;
  assign wb_err   = in_resp && err_q;
  assign wb_we    = in_resp && is_load_q && (rd_q != 5'd0) && !err_q;
  assign wb_data  = (in_resp && is_load_q && !err_q) ? ldata_q : '0;

endmodule

// File: tb/tb_cprv_lsu.sv
// Directed bench for cprv_lsu: writeback expectations are queued at issue and popped at completion.
module tb_cprv_lsu;
  import cprv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_load = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        err;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cprv_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_load   (req_is_load),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_err        (wb_err)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one op at a negedge in IDLE and walks it to completion at fixed cycle offsets,
  // so wb_valid being seen on the expected cycle is itself the latency check.
  task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] rdata, input int stall, input logic exp_err,
                        input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                        input logic [63:0] exp_data, input logic exp_we);
    wb_exp_t e;
    exp_q.push_back('{rd: rd, data: exp_data, we: exp_we, err: exp_err});
    check({tag, "/ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_is_load = ld; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_funct3 = 3'b111;
    req_addr = ~addr; req_wdata = ~wdata; req_rd = ~rd;
    if (!exp_err) begin
      for (int s = 0; s <= stall; s++) begin
        check({tag, "/mem_valid"}, mem_req_valid, 1);
        check({tag, "/mem_addr"}, mem_addr, {addr[63:3], 3'b000});
        check({tag, "/mem_we"}, mem_we, !ld);
        check({tag, "/mem_wstrb"}, mem_wstrb, exp_strb);
        check({tag, "/mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, "/ready_busy"}, req_ready, 0);
        mem_req_ready = (s == stall);
        mem_rsp_valid = (s < stall);
        mem_rdata = ~rdata;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      check({tag, "/wait_mem_valid"}, mem_req_valid, 0);
      check({tag, "/wait_wb_valid"}, wb_valid, 0);
      mem_rsp_valid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rdata = '0;
    end
    check({tag, "/resp_mem_valid"}, mem_req_valid, 0);
    check({tag, "/wb_valid"}, wb_valid, 1);
    e = exp_q.pop_front();
    check({tag, "/wb_rd"}, wb_rd, e.rd);
    check({tag, "/wb_data"}, wb_data, e.data);
    check({tag, "/wb_we"}, wb_we, e.we);
    check({tag, "/wb_err"}, wb_err, e.err);
    @(negedge clk);
    check({tag, "/wb_one_cycle"}, wb_valid, 0);
    check({tag, "/ready_after"}, req_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst/req_ready", req_ready, 0);
    check("rst/mem_req_valid", mem_req_valid, 0);
    check("rst/mem_wstrb", mem_wstrb, 0);
    check("rst/wb_valid", wb_valid, 0);
    check("rst/wb_data", wb_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready_after_release", req_ready, 1);

    run_op("lw_1004", 1, F3_W, 64'h1004, 64'hDEAD_BEEF_CAFE_F00D, 5'd5,
           64'h8000_0001_0000_0000, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001, 1);
    run_op("sb_2003", 0, F3_B, 64'h2003, 64'hAB, 5'd7,
           64'h5555_5555_5555_5555, 0, 0, 8'h08, 64'h0000_0000_AB00_0000, 64'h0, 0);
    run_op("lhu_3006", 1, F3_HU, 64'h3006, 64'h1, 5'd10,
           64'hFFEE_0000_0000_0000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_FFEE, 1);
    run_op("lh_3006", 1, F3_H, 64'h3006, 64'h1, 5'd11,
           64'hFFEE_0000_0000_0000, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFEE, 1);
    run_op("ld_err_4004", 1, F3_D, 64'h4004, 64'h0, 5'd9,
           64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);
    run_op("ld_rd0_stall3", 1, F3_D, 64'h8000, 64'h0, 5'd0,
           64'h0123_4567_89AB_CDEF, 3, 0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    run_op("sd_stall1", 0, F3_D, 64'h5000, 64'h1122_3344_5566_7788, 5'd3,
           64'h0, 1, 0, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0);
    run_op("sh_6002", 0, F3_H, 64'h6002, 64'hBEEF, 5'd4,
           64'h0, 0, 0, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0, 0);
    run_op("sw_7004", 0, F3_W, 64'h7004, 64'h1234_5678, 5'd6,
           64'h0, 0, 0, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 0);
    run_op("lb_7001", 1, F3_B, 64'h7001, 64'h0, 5'd12,
           64'h0000_0000_0000_8000, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1);
    run_op("lbu_7001", 1, F3_BU, 64'h7001, 64'h0, 5'd13,
           64'h0000_0000_0000_8000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_0080, 1);
    run_op("lwu_9000", 1, F3_WU, 64'h9000, 64'h0, 5'd14,
           64'h7777_7777_F000_0001, 0, 0, 8'h00, 64'h0, 64'h0000_0000_F000_0001, 1);
    run_op("sbu_err", 0, F3_BU, 64'hA000, 64'h1, 5'd15, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);
    run_op("f3_111_err", 1, 3'b111, 64'hA000, 64'h0, 5'd16, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);
    run_op("lw_mis_err", 1, F3_W, 64'hA002, 64'h0, 5'd17, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);
    run_op("lh_mis_err", 1, F3_H, 64'hA001, 64'h0, 5'd18, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);
    run_op("sd_mis_err", 0, F3_D, 64'hA004, 64'h0, 5'd19, 64'h0, 0, 1, 8'h00, 64'h0, 64'h0, 0);

    // Reset while waiting for the response; the late response must be dropped.
    req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = F3_W;
    req_addr = 64'hB000; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rstmid/in_wait", mem_req_valid, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid/ready_low", req_ready, 0);
    check("rstmid/wb_valid_low", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    check("rstmid/wb_valid_release", wb_valid, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    check("rstmid/late_rsp_wb", wb_valid, 0);
    check("rstmid/idle_ready", req_ready, 1);
    check("rstmid/no_mem_req", mem_req_valid, 0);
    @(negedge clk);
    check("rstmid/still_quiet", wb_valid, 0);

    run_op("lw_after_rst", 1, F3_W, 64'hC000, 64'h0, 5'd21,
           64'h0000_0000_0000_0042, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_0042, 1);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cprv_lsu.md
CPRV_LSU -- requirements
Module: cprv_lsu

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 64, register/bus data width; ADDR_WIDTH, default 64, address width.
REQ-002 Port clk  input  1  sole clock, rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port req_valid  input  1  execute stage presents a memory op.
REQ-005 Port req_ready  output  1  LSU accepts a request.
REQ-006 Port req_is_load  input  1  1=load, 0=store.
REQ-007 Port req_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 Port req_addr  input  ADDR_WIDTH  effective address (rs1+imm from ALU).
REQ-009 Port req_wdata  input  DATA_WIDTH  store data (rs2), LSB-justified.
REQ-010 Port req_rd  input  5  load destination register.
REQ-011 Ports mem_req_valid out 1 / mem_req_ready in 1 / mem_we out 1 / mem_addr out ADDR_WIDTH (bits[2:0]=0) / mem_wdata out DATA_WIDTH / mem_wstrb out 8: data-memory request channel.
REQ-012 Ports mem_rsp_valid in 1 / mem_rdata in DATA_WIDTH: response channel, one response per accepted request, loads and stores.
REQ-013 Ports wb_valid out 1 / wb_we out 1 / wb_rd out 5 / wb_data out DATA_WIDTH / wb_err out 1: completion to writeback.

Function
REQ-014 FSM SHALL have states IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-015 Accept on req_valid&&req_ready: latch all req_* fields; IDLE->REQ, or IDLE->RESP with wb_err=1 if error (REQ-016).
REQ-016 Error: funct3=111, store with funct3>=100, H with addr[0]!=0, W/WU with addr[1:0]!=0, D with addr[2:0]!=0; no memory request issued.
REQ-017 In REQ: mem_req_valid=1, mem_addr={addr[ADDR_WIDTH-1:3],3'b000}; all mem_* held stable until mem_req_ready; handshake cycle REQ->WAIT.
REQ-018 Store: mem_we=1, mem_wstrb = (B 0x01, H 0x03, W 0x0F, D 0xFF) << addr[2:0]; mem_wdata = req_wdata << 8*addr[2:0]. Load: mem_we=0, mem_wstrb=0.
REQ-019 WAIT->RESP on mem_rsp_valid; mem_rsp_valid outside WAIT ignored; mem_rdata captured that cycle.
REQ-020 Load data: shift mem_rdata right 8*addr[2:0], then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to 64 bits; D passes through.
REQ-021 RESP lasts exactly one cycle: wb_valid=1, wb_rd=latched rd, wb_we=is_load && rd!=0 && !err, wb_data=load result (0 for stores/errors); RESP->IDLE, no backpressure.
REQ-022 Minimum latency: accept cycle N, mem handshake N+1, response N+2, wb_valid N+3; error case wb_valid N+1.
REQ-023 All outputs other than those named in a state SHALL be 0.

Reset
REQ-024 rst_n low SHALL force IDLE asynchronously; req_ready=0 while rst_n low, then 1; all other outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it with no wb_valid; a late mem_rsp_valid after reset SHALL be ignored.

Structure
REQ-026 Shared package cprv_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, load/store funct3 encodings, and the LSU state enum.
REQ-027 One combinational sub-module cprv_lsu_align SHALL implement strobe generation, store lane shifting and load extraction/extension.

Verification
REQ-028 LW addr 0x1004, mem_rdata 0x8000_0001_0000_0000, rd=5 -> mem_addr 0x1000, wb_data 0xFFFF_FFFF_8000_0001, wb_we=1, wb_valid at N+3.
REQ-029 SB addr 0x2003, wdata 0xAB -> mem_wstrb 0x08, mem_wdata 0x0000_0000_AB00_0000, wb_we=0.
REQ-030 LHU addr 0x3006, rdata 0xFFEE_0000_0000_0000 -> wb_data 0x0000_0000_0000_FFEE; LH same -> 0xFFFF_FFFF_FFFF_FFEE.
REQ-031 LD addr 0x4004 -> no mem_req_valid, wb_valid at N+1 with wb_err=1, wb_we=0.
REQ-032 mem_req_ready low 3 cycles -> mem_* stable, req_ready=0 throughout; load rd=0 -> wb_we=0.
REQ-033 rst_n low in WAIT, response arrives after release -> no wb_valid, FSM IDLE, req_ready=1.
